// File: rtl/devil_campaign_sequencer.sv
// Campaign sequencer for devil_in_fpga: steps an entry table through LOAD/ARM/RUN/GAP and drives the devil registers.
// Optional RUN watchdog is compiled in with `define DEVIL_SEQ_TIMEOUT_EN.
module devil_campaign_sequencer #(
    parameter int N_ENTRIES   = 8,
    parameter int GAP_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 65536,
    localparam int AW = $clog2(N_ENTRIES)
) (
    input  logic          ace_aclk,
    input  logic          ace_aresetn,
    input  logic          i_tbl_we,
    input  logic [AW-1:0] i_tbl_addr,
    input  logic [63:0]   i_tbl_wdata,
    input  logic [AW:0]   i_num_entries,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [3:0]    i_fsm_devil_state,
    output logic [31:0]   o_control_reg,
    output logic [31:0]   o_delay_reg,
    output logic [31:0]   o_acsnoop_reg,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_cur_entry,
    output logic [15:0]   o_pass_cnt,
    output logic [2:0]    o_err,
    output logic [2:0]    o_dbg_state
);
    localparam int NW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_RUN  = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     ctrl_q, ctrl_d;
    logic [31:0]     delay_q, delay_d;
    logic [3:0]      acs_q, acs_d;
    logic [AW-1:0]   entry_q, entry_d;
    logic [AW:0]     num_q, num_d;
    logic [15:0]     pass_q, pass_d;
    logic [2:0]      err_q, err_d;
    logic            done_q, done_d;
    logic            con_q, con_d;
    logic            seen_q, seen_d;
    logic [15:0]     rep_q, rep_d;
    logic [15:0]     rsp_cnt_q, rsp_cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [3:0]      prev_q;
    logic            rise;
    logic            complete;
    logic            run_end;

    logic [63:0]     tbl_q [N_ENTRIES];
    logic [63:0]     tbl_rd;
    logic            unused_tbl_bits;

`ifdef DEVIL_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0]   wd_q, wd_d;
`endif

    // Table is storage only: no reset, writes accepted while idle.
    always_ff @(posedge ace_aclk) begin
        if (ace_aresetn && i_tbl_we && state_q == S_IDLE) begin
            tbl_q[i_tbl_addr] <= i_tbl_wdata;
        end
    end

    assign tbl_rd          = tbl_q[entry_q];
    assign unused_tbl_bits = ^tbl_rd[15:14];
    assign rise            = (i_fsm_devil_state == 4'd3) && (prev_q != 4'd3);

    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            delay_q   <= '0;
            acs_q     <= '0;
            entry_q   <= '0;
            num_q     <= '0;
            pass_q    <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            con_q     <= 1'b0;
            seen_q    <= 1'b0;
            rep_q     <= '0;
            rsp_cnt_q <= '0;
            gap_q     <= '0;
            prev_q    <= '0;
`ifdef DEVIL_SEQ_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            delay_q   <= delay_d;
            acs_q     <= acs_d;
            entry_q   <= entry_d;
            num_q     <= num_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            done_q    <= done_d;
            con_q     <= con_d;
            seen_q    <= seen_d;
            rep_q     <= rep_d;
            rsp_cnt_q <= rsp_cnt_d;
            gap_q     <= gap_d;
            prev_q    <= i_fsm_devil_state;
`ifdef DEVIL_SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        delay_d   = delay_q;
        acs_d     = acs_q;
        entry_d   = entry_q;
        num_d     = num_q;
        pass_d    = pass_q;
        err_d     = err_q;
        done_d    = 1'b0;
        con_d     = con_q;
        seen_d    = seen_q;
        rep_d     = rep_q;
        rsp_cnt_d = rsp_cnt_q;
        gap_d     = gap_q;
        complete  = 1'b0;
        run_end   = 1'b0;
`ifdef DEVIL_SEQ_TIMEOUT_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    pass_d  = '0;
                    err_d   = '0;
                    entry_d = '0;
                    num_d   = i_num_entries;
                    state_d = (i_num_entries == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                ctrl_d    = {14'b0, 2'b00, tbl_rd[9], tbl_rd[8], 5'b0,
                             tbl_rd[7:4], tbl_rd[3:0], 1'b0};
                delay_d   = tbl_rd[47:16];
                acs_d     = tbl_rd[13:10];
                con_d     = (tbl_rd[7:4] == 4'd1);
                rep_d     = (tbl_rd[63:48] == 16'd0) ? 16'd1 : tbl_rd[63:48];
                seen_d    = 1'b0;
                rsp_cnt_d = '0;
                state_d   = S_ARM;
            end
            S_ARM: begin
                if (con_q) ctrl_d[17] = 1'b1;
                else       ctrl_d[16] = 1'b1;
`ifdef DEVIL_SEQ_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
                if (con_q) begin
                    if (rise) begin
                        rsp_cnt_d = rsp_cnt_q + 16'd1;
                        complete  = ((rsp_cnt_q + 16'd1) == rep_q);
                    end
                end else begin
                    seen_d   = seen_q | (i_fsm_devil_state != 4'd0);
                    complete = (i_fsm_devil_state == 4'd7) ||
                               (i_fsm_devil_state == 4'd0 && seen_q);
                end
                run_end = complete;
`ifdef DEVIL_SEQ_TIMEOUT_EN
                wd_d = wd_q + WW'(1);
                if (!complete && wd_q == WW'(TIMEOUT_CYC - 1)) begin
                    run_end  = 1'b1;
                    err_d[0] = 1'b1;
                end
`endif
                if (run_end) begin
                    ctrl_d[17:16] = 2'b00;
                    gap_d         = '0;
                    state_d       = S_GAP;
                    if (complete && pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
                end
            end
            S_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    if (({1'b0, entry_q} + NW'(1)) == num_q) begin
                        state_d = S_DONE;
                    end else begin
                        entry_d = entry_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (i_tbl_we && state_q != S_IDLE) err_d[2] = 1'b1;

        // Abort overrides whatever the state decided this cycle.
        if (i_abort && state_q != S_IDLE) begin
            ctrl_d[17:16] = 2'b00;
            err_d[1]      = 1'b1;
            done_d        = 1'b0;
            state_d       = S_IDLE;
        end
    end

    assign o_control_reg = ctrl_q;
    assign o_delay_reg   = delay_q;
    assign o_acsnoop_reg = {28'b0, acs_q};
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;
    assign o_cur_entry   = entry_q;
    assign o_pass_cnt    = pass_q;
    assign o_err         = err_q;
    assign o_dbg_state   = state_q;

endmodule
